rv32i_instr_encoder: RTL and testbench

Packs RV32I instruction fields (format, opcode, register indices, funct fields, signed immediate) into 32-bit machine words and buffers them in a small FIFO for instruction memory or the fetch path to consume. It is the producer-side counterpart of the instruction decoder: a word encoded here and fed to the decoder must return the same field values. Both sides use valid/ready handshakes. Immediate range and alignment errors are flagged per word. An error counter is kept for bench and loader use.

---
 rtl/rv32i_pkg.sv | 46 ++++
 rtl/rv32i_enc_fifo.sv | 77 +++++++
 rtl/rv32i_instr_encoder.sv | 124 ++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I constants for the instruction encoder (and its decoder peer):
//   - fmt_e       : instruction format selector carried on the 3-bit fmt port
//   - OPC_*       : base opcodes used by the encoder and its users
//   - NOP_INSTR   : canonical NOP (addi x0,x0,0), substituted for illegal fmt
//   - sext_fits() : true when a 32-bit value is the sign extension of its
//                   low (sign_bit+1) bits
// -----------------------------------------------------------------------------
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_ILL6 = 3'd6,
    FMT_ILL7 = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // funct3 values that turn an OP_IMM into a shift-immediate
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Every bit from sign_bit upward must be identical for the value to be
  // representable in a (sign_bit+1)-bit signed field.
  function automatic logic sext_fits(input logic [31:0] value,
                                     input logic [4:0]  sign_bit);
    logic [31:0] upper_mask;
    upper_mask = 32'hFFFF_FFFF << sign_bit;
    return ((value & upper_mask) == 32'd0) || ((value & upper_mask) == upper_mask);
  endfunction

endpackage

// File: rtl/rv32i_enc_fifo.sv
// -----------------------------------------------------------------------------
// rv32i_enc_fifo
// DEPTH-entry synchronous FIFO with occupancy counter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_valid / wr_ready : write handshake; wr_ready = (count < DEPTH)
//   wr_data             : WIDTH-bit entry
//   rd_valid / rd_ready : read handshake; rd_valid = (count != 0)
//   rd_data             : head entry (zero while empty)
//   count               : occupancy, $clog2(DEPTH)+1 bits
// Pointers are $clog2(DEPTH) bits and wrap naturally, so DEPTH must be a
// power of two. wr_ready looks only at count: a full FIFO refuses a write
// even when a read happens in the same cycle.
// -----------------------------------------------------------------------------
module rv32i_enc_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_wr, do_rd;

  assign wr_ready = (count_q < DEPTH_CNT);
  assign rd_valid = (count_q != '0);
  assign do_wr    = wr_valid && wr_ready;
  assign do_rd    = rd_valid && rd_ready;
  assign count    = count_q;

  // Storage is not reset; the head is masked while empty so the output
  // reads zero out of reset.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// -----------------------------------------------------------------------------
// rv32i_instr_encoder
// Packs RV32I fields into 32-bit instruction words, flags immediate range and
// alignment errors, and queues {err, word} pairs in a DEPTH-entry FIFO.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : field-tuple handshake (in_ready = count < DEPTH)
//   fmt                  : R=0 I=1 S=2 B=3 U=4 J=5, 6/7 illegal
//   opcode, rd, rs1, rs2, funct3, funct7, imm : instruction fields
//                          (imm is the signed, unshifted immediate)
//   out_valid / out_ready: head-word handshake
//   out_instr, out_err   : head word and its error flag
//   count                : FIFO occupancy
//   err_count            : accepted error words, saturating at 255
// -----------------------------------------------------------------------------
module rv32i_instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             fmt,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  input  logic [31:0]            imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             err_count
);

  import rv32i_pkg::*;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        is_shift;
  logic        push;
  logic [32:0] head_entry;
  logic [7:0]  err_count_q, err_count_d;

  // Shift-immediates reuse the I slot: funct7 occupies imm[11:5] and only a
  // 5-bit unsigned shift amount is legal.
  assign is_shift = (opcode == OPC_OP_IMM) &&
                    ((funct3 == F3_SLLI) || (funct3 == F3_SRXI));

  always_comb begin
    enc_word = NOP_INSTR;
    enc_err  = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        if (is_shift) begin
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          enc_err  = (imm[31:5] != 27'd0);
        end else begin
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
          enc_err  = !sext_fits(imm, 5'd11);
        end
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !sext_fits(imm, 5'd11);
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = !sext_fits(imm, 5'd12) || imm[0];
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = !sext_fits(imm, 5'd20) || imm[0];
      end
      default: begin
        enc_word = NOP_INSTR;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign push = in_valid && in_ready;

  always_comb begin
    err_count_d = err_count_q;
    if (push && enc_err && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= 8'd0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;

  rv32i_enc_fifo #(
    .WIDTH (33),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  ({enc_err, enc_word}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (head_entry),
    .count    (count)
  );

  assign out_instr = head_entry[31:0];
  assign out_err   = head_entry[32];

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
module tb_rv32i_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [2:0]  count;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: expected FIFO contents {err, word} and error count
  logic [32:0] mq[$];
  int          m_errc = 0;

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .count     (count),
    .err_count (err_count)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    logic [31:0] m;
    m = (32'd1 << (hi - lo + 1)) - 32'd1;
    return (v >> lo) & m;
  endfunction

  // Reference encoder: builds the word by adding each field at its bit
  // position and judges immediates by signed numeric range.
  function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] opc,
                                          input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] im);
    int          s;
    logic [31:0] w;
    logic        e;
    logic [31:0] base_rd;
    s = $signed(im);
    e = 1'b0;
    base_rd = 32'(opc) + (32'(d) << 7) + (32'(f3) << 12) + (32'(s1) << 15);
    case (f)
      3'd0: w = base_rd + (32'(s2) << 20) + (32'(f7) << 25);
      3'd1: begin
        if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = base_rd + (fld(im, 4, 0) << 20) + (32'(f7) << 25);
          e = (im > 32'd31);
        end else begin
          w = base_rd + (fld(im, 11, 0) << 20);
          e = (s < -2048) || (s > 2047);
        end
      end
      3'd2: begin
        w = 32'(opc) + (fld(im, 4, 0) << 7) + (32'(f3) << 12) + (32'(s1) << 15) +
            (32'(s2) << 20) + (fld(im, 11, 5) << 25);
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = 32'(opc) + (fld(im, 11, 11) << 7) + (fld(im, 4, 1) << 8) + (32'(f3) << 12) +
            (32'(s1) << 15) + (32'(s2) << 20) + (fld(im, 10, 5) << 25) + (fld(im, 12, 12) << 31);
        e = (s < -4096) || (s > 4095) || (s % 2 != 0);
      end
      3'd4: begin
        w = 32'(opc) + (32'(d) << 7) + (im & 32'hFFFF_F000);
        e = ((im & 32'h0000_0FFF) != 32'd0);
      end
      3'd5: begin
        w = 32'(opc) + (32'(d) << 7) + (fld(im, 19, 12) << 12) + (fld(im, 11, 11) << 20) +
            (fld(im, 10, 1) << 21) + (fld(im, 20, 20) << 31);
        e = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  // One clock: check outputs against the model, advance one edge, update model.
  task automatic step();
    logic        do_push, do_pop;
    logic [32:0] e;
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("err_count", 32'(err_count), 32'(m_errc));
    if (mq.size() != 0) begin
      chk("out_instr", out_instr, mq[0][31:0]);
      chk("out_err", 32'(out_err), 32'(mq[0][32]));
    end
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = out_ready && (mq.size() != 0);
    e = ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
    @(posedge clk); #1;
    if (do_pop) begin
      $display("[%0t] pop  word=%08h err=%0b", $time, mq[0][31:0], mq[0][32]);
      void'(mq.pop_front());
    end
    if (do_push) begin
      mq.push_back(e);
      if (e[32] && m_errc < 255) m_errc++;
      $display("[%0t] push fmt=%0d imm=%08h word=%08h err=%0b", $time, fmt, imm, e[31:0], e[32]);
    end
  endtask

  task automatic set_in(input logic v, input logic [2:0] f, input logic [6:0] opc,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    in_valid = v; fmt = f; opcode = opc; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic set_random(input logic v);
    logic [2:0]  f;
    logic [6:0]  opc;
    logic [31:0] im;
    f = 3'($urandom_range(0, 7));
    case (f)
      3'd0: opc = 7'h33;
      3'd1: opc = ($urandom % 2 == 0) ? 7'h13 : 7'h03;
      3'd2: opc = 7'h23;
      3'd3: opc = 7'h63;
      3'd4: opc = 7'h37;
      3'd5: opc = 7'h6F;
      default: opc = 7'($urandom);
    endcase
    case ($urandom % 5)
      0: im = $urandom;
      1: im = 32'(int'($urandom_range(0, 8191)) - 4096);
      2: im = 32'(int'($urandom_range(0, 4194303)) - 2097152);
      3: im = $urandom & 32'hFFFF_F000;
      default: im = 32'($urandom_range(0, 40));
    endcase
    set_in(v, f, opc, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), im);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [6:0]  opc;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] im;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int exp_errc;

    //             fmt   opc    rd  rs1 rs2 f3    f7     imm            word           err
    vecs[0]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        32'h002081B3, 1'b0}; // add x3,x1,x2
    vecs[1]  = '{3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00508113, 1'b0}; // addi x2,x1,5
    vecs[2]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423, 1'b0}; // sw x2,8(x1)
    vecs[3]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0}; // beq x1,x2,-4
    vecs[4]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,        32'h008000EF, 1'b0}; // jal x1,8
    vecs[5]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,        32'h00208163, 1'b1}; // B odd
    vecs[6]  = '{3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h80008113, 1'b1}; // I range
    vecs[7]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001001, 32'h000012B7, 1'b1}; // U low bits
    vecs[8]  = '{3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        32'h00000013, 1'b1}; // illegal fmt
    vecs[9]  = '{3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd31,       32'h41F35293, 1'b0}; // srai x5,x6,31
    vecs[10] = '{3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd1, 7'h00, 32'd32,       32'h00031293, 1'b1}; // slli shamt 32
    vecs[11] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h8000006F, 1'b0}; // J min
    vecs[12] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,     32'h7E000FE3, 1'b0}; // B max

    // ---------------- reset ----------------
    rst_n = 1'b0;
    out_ready = 1'b0;
    set_in(1'b1, 3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- table: one tuple at a time ----------------
    exp_errc = 0;
    for (int i = 0; i < 13; i++) begin
      set_in(1'b1, vecs[i].f, vecs[i].opc, vecs[i].d, vecs[i].s1, vecs[i].s2,
             vecs[i].f3, vecs[i].f7, vecs[i].im);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      if (vecs[i].exp_err) exp_errc++;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_word);
      chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(exp_errc));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    // ---------------- four back-to-back, popped in order ----------------
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b1, vecs[k].f, vecs[k].opc, vecs[k].d, vecs[k].s1, vecs[k].s2,
             vecs[k].f3, vecs[k].f7, vecs[k].im);
      step();
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("b2b_order%0d", k), out_instr, vecs[k].exp_word);
      step();
    end
    out_ready = 1'b0;
    chk("b2b_empty", 32'(out_valid), 32'd0);

    // ---------------- full / back-pressure ----------------
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 3'd1, 7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 10));
      chk($sformatf("full_in_ready%0d", k), 32'(in_ready), 32'(k < 4));
      step();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_held", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b1;
    chk("full_no_pushthrough", 32'(in_ready), 32'd0);
    step();
    chk("full_count3", 32'(count), 32'd3);
    chk("full_ready_again", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("full_drained", 32'(count), 32'd0);

    // ---------------- simultaneous push/pop at count=2, pointer wrap ----------------
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_random(1'b1);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      set_random(1'b1);
      chk($sformatf("pp_count%0d", k), 32'(count), 32'd2);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();

    // ---------------- reset mid-transfer ----------------
    out_ready = 1'b0;
    set_in(1'b1, 3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step();
    set_random(1'b1);
    step();
    set_random(1'b1);
    step();
    chk("mid_count3", 32'(count), 32'd3);
    set_random(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    mq.delete();
    m_errc = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_rst_ignored", 32'(count), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    set_in(1'b1, vecs[0].f, vecs[0].opc, vecs[0].d, vecs[0].s1, vecs[0].s2,
           vecs[0].f3, vecs[0].f7, vecs[0].im);
    step();
    in_valid = 1'b0;
    chk("post_rst_instr", out_instr, 32'h002081B3);
    chk("post_rst_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 500; c++) begin
      set_random($urandom % 4 != 0);
      out_ready = ($urandom % 3 != 0);
      step();
    end

    // ---------------- err_count saturation ----------------
    out_ready = 1'b1;
    for (int c = 0; c < 270; c++) begin
      set_in(1'b1, 3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      step();
    end
    chk("sat_err_count", 32'(err_count), 32'd255);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
